// File: rtl/lsu_pkg.sv
// Shared constants, FSM state type and request-decode helpers for the load/store unit memory port.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    // The size lives in funct3[1:0]; the sign bit funct3[2] does not affect lanes.
    function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b00:   be_gen = 4'b0001 << off;
            2'b01:   be_gen = 4'b0011 << off;
            default: be_gen = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
        if (we) begin
            funct3_illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        end else begin
            funct3_illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                               funct3 == F3_BU || funct3 == F3_HU);
        end
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Moves the addressed byte/half/word of a memory read word to bit 0 and sign- or zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_lane;

    assign w_lane = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_data = '0;
        case (i_funct3)
            F3_B:    o_data = {{24{w_lane[7]}}, w_lane[7:0]};
            F3_H:    o_data = {{16{w_lane[15]}}, w_lane[15:0]};
            F3_W:    o_data = w_lane;
            F3_BU:   o_data = {24'h0, w_lane[7:0]};
            F3_HU:   o_data = {16'h0, w_lane[15:0]};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store initiator for a 1-cycle synchronous data memory:
// IDLE drives the memory port from the request, DATA captures the read word, RESP holds the response.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH = 32,
    parameter int DATA_BYTES = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [2:0]            i_req_funct3,
    input  logic [31:0]           i_req_addr,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [31:0]           o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [DATA_BYTES-1:0] o_mem_wen,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    lsu_state_e r_state;
    lsu_state_e w_state_nxt;

    logic [1:0]            r_off;
    logic [2:0]            r_funct3;
    logic                  r_we;
    logic                  r_err;
    logic                  r_rsp_valid;
    logic [31:0]           r_rsp_rdata;
    logic                  r_rsp_err;
    logic [DATA_BYTES-1:0] w_be;
    logic                  w_req_err;
    logic                  w_accept;
    logic [31:0]           w_load_data;
    logic                  w_unused_addr;

    assign w_be      = be_gen(i_req_funct3, i_req_addr[1:0]);
    assign w_req_err = funct3_illegal(i_req_we, i_req_funct3) |
                       misaligned(i_req_funct3, i_req_addr[1:0]);
    assign w_accept  = i_req_valid & o_req_ready;

    // Upper byte-address bits wrap modulo the memory size.
    assign o_mem_addr    = i_req_addr[ADDR_WIDTH+1:2];
    assign w_unused_addr = ^i_req_addr[31:ADDR_WIDTH+2];

    always_comb begin
        o_mem_wdata = i_req_wdata;
        case (i_req_funct3[1:0])
            2'b00:   o_mem_wdata = {4{i_req_wdata[7:0]}};
            2'b01:   o_mem_wdata = {2{i_req_wdata[15:0]}};
            default: o_mem_wdata = i_req_wdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = DATA;
            DATA:    w_state_nxt = RESP;
            RESP:    if (i_rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Gating with rst_n keeps the memory untouched while reset is held.
    always_comb begin
        o_req_ready = 1'b0;
        o_mem_wen   = '0;
        if (r_state == IDLE) begin
            o_req_ready = rst_n;
            if (rst_n && i_req_valid && i_req_we && !w_req_err) begin
                o_mem_wen = w_be;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_off    <= '0;
            r_funct3 <= '0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_off    <= i_req_addr[1:0];
            r_funct3 <= i_req_funct3;
            r_we     <= i_req_we;
            r_err    <= w_req_err;
        end
    end

    lsu_load_align u_load_align (
        .i_rdata  (i_mem_rdata),
        .i_off    (r_off),
        .i_funct3 (r_funct3),
        .o_data   (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (r_state == DATA) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= (r_we || r_err) ? 32'h0 : w_load_data;
            r_rsp_err   <= r_err;
        end else if (r_state == RESP && i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: write-first behavioural memory, byte-array reference model, response scoreboard.
module tb_lsu_mem_ctrl;

    localparam int DEPTH      = 2048;
    localparam int ADDR_WIDTH = 11;

    logic                  clk;
    logic                  rst_n;
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic                  i_req_we;
    logic [2:0]            i_req_funct3;
    logic [31:0]           i_req_addr;
    logic [31:0]           i_req_wdata;
    logic                  o_rsp_valid;
    logic                  i_rsp_ready;
    logic [31:0]           o_rsp_rdata;
    logic                  o_rsp_err;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [31:0]           o_mem_wdata;
    logic [3:0]            o_mem_wen;
    logic [31:0]           i_mem_rdata;

    lsu_mem_ctrl #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_funct3 (i_req_funct3),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_err    (o_rsp_err),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_wen    (o_mem_wen),
        .i_mem_rdata  (i_mem_rdata)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- write-first memory ----------------
    logic [31:0] mem_arr [DEPTH];
    logic [31:0] mem_rdata_q;
    logic [31:0] w_merged;

    always_comb begin
        w_merged = mem_arr[o_mem_addr];
        for (int i = 0; i < 4; i++) begin
            if (o_mem_wen[i]) w_merged[8*i +: 8] = o_mem_wdata[8*i +: 8];
        end
    end

    always @(posedge clk) begin
        if (|o_mem_wen) mem_arr[o_mem_addr] <= w_merged;
        mem_rdata_q <= w_merged;
    end

    assign i_mem_rdata = mem_rdata_q;

    // ---------------- scoreboard state ----------------
    logic [7:0]  ref_mem [DEPTH*4];
    logic [32:0] exp_q [$];
    int          n_checks;
    int          n_pass;
    bit          rdy_rand;
    bit          rdy_force;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- response-ready driver ----------------
    initial begin
        i_rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            i_rsp_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [32:0] e;
        bit          hold;
        logic [31:0] h_rdata;
        logic        h_err;
        hold = 0;
        h_rdata = '0;
        h_err = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 0;
            end else if (o_rsp_valid) begin
                if (hold) begin
                    chk("rsp_rdata_stable", o_rsp_rdata, h_rdata);
                    chk("rsp_err_stable", {31'b0, o_rsp_err}, {31'b0, h_err});
                end
                if (i_rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_rsp: got rdata %h err %b, none expected", o_rsp_rdata, o_rsp_err);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", o_rsp_rdata, e[31:0]);
                        chk("rsp_err", {31'b0, o_rsp_err}, {31'b0, e[32]});
                    end
                    hold = 0;
                end else begin
                    hold = 1;
                    h_rdata = o_rsp_rdata;
                    h_err = o_rsp_err;
                end
            end
        end
    end

    // ---------------- request driver + reference model ----------------
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit check_lat);
        int          size;
        int          word;
        int          base;
        int          off;
        int          waited;
        bit          legal;
        bit          err;
        logic [3:0]  e_wen;
        logic [31:0] e_wdata;
        logic [31:0] v;

        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off   = int'(addr % 4);
        word  = int'((addr / 4) % DEPTH);
        base  = word * 4;
        err   = !legal || ((addr % size) != 0);
        e_wen = '0;
        if (we && !err) begin
            for (int j = 0; j < size; j++) e_wen[off + j] = 1'b1;
        end
        for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = wdata[8*(i % size) +: 8];

        @(posedge clk);
        #1;
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wdata;

        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!o_req_ready && waited < 100);
        if (!o_req_ready) begin
            n_checks++;
            $display("FAIL req_timeout: ready still %b after %0d cycles", o_req_ready, waited);
            i_req_valid = 1'b0;
            return;
        end

        chk("mem_wen", {28'b0, o_mem_wen}, {28'b0, e_wen});
        chk("mem_addr", {21'b0, o_mem_addr}, word);
        if (we && legal) chk("mem_wdata", o_mem_wdata, e_wdata);

        v = '0;
        if (!err && we) begin
            for (int j = 0; j < size; j++) ref_mem[base + off + j] = wdata[8*j +: 8];
        end else if (!err) begin
            for (int j = 0; j < size; j++) v[8*j +: 8] = ref_mem[base + off + j];
            if (!f3[2] && size < 4 && v[8*size - 1]) v = v | (32'hFFFF_FFFF << (8*size));
        end
        exp_q.push_back({err, v});

        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        if (check_lat) begin
            @(negedge clk);
            chk("lat_data_valid", {31'b0, o_rsp_valid}, 32'd0);
            chk("lat_data_ready", {31'b0, o_req_ready}, 32'd0);
            @(negedge clk);
            chk("lat_resp_valid", {31'b0, o_rsp_valid}, 32'd1);
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || o_rsp_valid) && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (c >= 200) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;

        n_checks = 0;
        n_pass = 0;
        rdy_rand = 0;
        rdy_force = 0;
        rst_n = 1'b0;
        i_req_valid = 1'b0;
        i_req_we = 1'b0;
        i_req_funct3 = 3'd0;
        i_req_addr = 32'h0;
        i_req_wdata = 32'h0;
        for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'b0, o_rsp_err}, 32'd0);
        chk("rst_req_ready", {31'b0, o_req_ready}, 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, o_req_ready}, 32'd1);

        rdy_rand = 1;
        for (int w = 0; w < 16; w++) do_req(1'b1, 3'd2, w * 4, $urandom, 1'b1);

        // Directed lane, extension, error and wrap cases.
        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
        do_req(1'b1, 3'd0, 32'h13, 32'h000000A5, 1'b1);
        do_req(1'b0, 3'd0, 32'h13, 32'h0, 1'b1);
        do_req(1'b0, 3'd4, 32'h13, 32'h0, 1'b1);
        do_req(1'b1, 3'd2, 32'h10, 32'h80011234, 1'b1);
        do_req(1'b0, 3'd1, 32'h12, 32'h0, 1'b1);
        do_req(1'b0, 3'd5, 32'h12, 32'h0, 1'b1);
        do_req(1'b1, 3'd1, 32'h11, 32'h0000CAFE, 1'b1);
        do_req(1'b0, 3'd2, 32'h02, 32'h0, 1'b1);
        do_req(1'b0, 3'd3, 32'h10, 32'h0, 1'b1);
        do_req(1'b1, 3'd3, 32'h10, 32'h55555555, 1'b1);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
        do_req(1'b1, 3'd1, 32'h0001_2016, 32'h00007E57, 1'b1);
        do_req(1'b0, 3'd2, 32'h14, 32'h0, 1'b1);

        // Back-pressure: response must hold while ready is low.
        drain();
        @(posedge clk);
        #1;
        rdy_rand = 0;
        rdy_force = 0;
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp_valid", {31'b0, o_rsp_valid}, 32'd1);
            chk("hold_req_ready", {31'b0, o_req_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rdy_force = 1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("release_req_ready", {31'b0, o_req_ready}, 32'd1);
        chk("release_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
        rdy_rand = 1;

        // Reset while in DATA: response dropped, committed store kept, no write under reset.
        drain();
        do_req(1'b1, 3'd2, 32'h20, 32'h11223344, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
        chk("midrst_req_ready", {31'b0, o_req_ready}, 32'd0);
        void'(exp_q.pop_back());
        i_req_valid = 1'b1;
        i_req_we = 1'b1;
        i_req_funct3 = 3'd2;
        i_req_addr = 32'h20;
        i_req_wdata = 32'hBAD0BAD0;
        #1;
        chk("midrst_mem_wen", {28'b0, o_mem_wen}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_release_ready", {31'b0, o_req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_stale", {31'b0, o_rsp_valid}, 32'd0);
            @(negedge clk);
        end
        do_req(1'b0, 3'd2, 32'h20, 32'h0, 1'b1);

        // Randomized traffic over 16 words, with high address bits exercising the wrap.
        for (int n = 0; n < 250; n++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            addr = $urandom & 32'hFFFF_E03F;
            do_req(we, f3, addr, $urandom, 1'b1);
        end

        drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
